mips_multicycle_control: RTL and testbench

- Main control FSM for the multicycle MIPS datapath: the producer side of the ALUOp interface consumed by the ALU control decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Issues datapath enables, mux selects and ALUOp (00 = add, 01 = subtract, 10 = decode from funct).
- Stalls on a single-port memory ready handshake.

---
 rtl/mips_ctrl_pkg.sv | 63 ++++++
 rtl/mips_multicycle_control_if.sv | 36 +++
 rtl/mips_multicycle_control.sv | 164 ++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM: state numbering,
// opcodes, ALUOp codes and datapath mux selects.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXECUTE   = 4'd6,
      R_WB      = 4'd7,
      BRANCH    = 4'd8,
      JUMP      = 4'd9,
      ADDI_EX   = 4'd10,
      ADDI_WB   = 4'd11
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] ALUB_REG    = 2'b00;
   localparam logic [1:0] ALUB_FOUR   = 2'b01;
   localparam logic [1:0] ALUB_IMM    = 2'b10;
   localparam logic [1:0] ALUB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       illegal_op;
      logic       mem_timeout;
   } ctrl_t;

   // States that talk to the single-port memory and may stall on mem_ready.
   function automatic logic is_mem_state(state_e s);
      return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
   endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the main control FSM (ctrl) and the multicycle
// datapath (datapath). Levels, no handshake except mem_ready completing an access.
interface mips_multicycle_control_if;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_write;
   logic       pc_write_cond;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       mem_to_reg;
   logic       reg_dst;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] pc_source;
   logic       illegal_op;
   logic       mem_timeout;

   modport ctrl (
      input  opcode, zero, mem_ready,
      output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, illegal_op, mem_timeout
   );

   modport datapath (
      output opcode, zero, mem_ready,
      input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, illegal_op, mem_timeout
   );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS: sequences fetch/decode/execute/
// memory/writeback, stalls on mem_ready and aborts memory waits after MEM_WAIT_MAX.
module mips_multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter logic [7:0] MEM_WAIT_MAX = 8'd255
) (
   input  logic                          clk,
   input  logic                          rst_n,
   mips_multicycle_control_if.ctrl       bus,
   output logic [3:0]                    state_dbg
);

   state_e     state, state_next;
   logic [7:0] wait_cnt;
   logic       wait_expired;
   logic       timeout;
   logic       illegal;
   ctrl_t      ctl, ctl_out;
   logic       unused_zero;

   // The branch decision itself is made in the datapath from zero and pc_write_cond.
   assign unused_zero  = bus.zero;
   assign wait_expired = (wait_cnt == MEM_WAIT_MAX) && !bus.mem_ready;

   always_comb begin
      state_next = FETCH;
      timeout    = 1'b0;
      illegal    = 1'b0;
      case (state)
         FETCH: begin
            if (bus.mem_ready)     state_next = DECODE;
            else if (wait_expired) timeout    = 1'b1;
            else                   state_next = FETCH;
         end
         DECODE: begin
            case (bus.opcode)
               OP_LW, OP_SW: state_next = MEM_ADDR;
               OP_RTYPE:     state_next = EXECUTE;
               OP_BEQ:       state_next = BRANCH;
               OP_J:         state_next = JUMP;
               OP_ADDI:      state_next = ADDI_EX;
               default:      illegal    = 1'b1;
            endcase
         end
         MEM_ADDR: begin
            if (bus.opcode == OP_LW)      state_next = MEM_READ;
            else if (bus.opcode == OP_SW) state_next = MEM_WRITE;
         end
         MEM_READ: begin
            if (bus.mem_ready)     state_next = MEM_WB;
            else if (wait_expired) timeout    = 1'b1;
            else                   state_next = MEM_READ;
         end
         MEM_WRITE: begin
            if (!bus.mem_ready && wait_expired) timeout    = 1'b1;
            else if (!bus.mem_ready)            state_next = MEM_WRITE;
         end
         EXECUTE: state_next = R_WB;
         ADDI_EX: state_next = ADDI_WB;
         default: state_next = FETCH;
      endcase
   end

   always_comb begin
      ctl = '0;
      case (state)
         FETCH: begin
            ctl.mem_read  = 1'b1;
            ctl.alu_src_b = ALUB_FOUR;
            ctl.alu_op    = ALUOP_ADD;
            ctl.pc_source = PCSRC_ALU;
            ctl.ir_write  = bus.mem_ready;
            ctl.pc_write  = bus.mem_ready;
         end
         DECODE: begin
            ctl.alu_src_b = ALUB_IMM_SH;
            ctl.alu_op    = ALUOP_ADD;
         end
         MEM_ADDR, ADDI_EX: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = ALUB_IMM;
            ctl.alu_op    = ALUOP_ADD;
         end
         MEM_READ: begin
            ctl.mem_read = 1'b1;
            ctl.i_or_d   = 1'b1;
         end
         MEM_WB: begin
            ctl.reg_write  = 1'b1;
            ctl.mem_to_reg = 1'b1;
         end
         MEM_WRITE: begin
            ctl.mem_write = 1'b1;
            ctl.i_or_d    = 1'b1;
         end
         EXECUTE: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = ALUB_REG;
            ctl.alu_op    = ALUOP_FUNCT;
         end
         R_WB: begin
            ctl.reg_write = 1'b1;
            ctl.reg_dst   = 1'b1;
         end
         BRANCH: begin
            ctl.alu_src_a     = 1'b1;
            ctl.alu_src_b     = ALUB_REG;
            ctl.alu_op        = ALUOP_SUB;
            ctl.pc_write_cond = 1'b1;
            ctl.pc_source     = PCSRC_ALUOUT;
         end
         JUMP: begin
            ctl.pc_write  = 1'b1;
            ctl.pc_source = PCSRC_JUMP;
         end
         ADDI_WB: ctl.reg_write = 1'b1;
         default: ctl = '0;
      endcase
      ctl.illegal_op  = illegal;
      ctl.mem_timeout = timeout;
      // A timed-out fetch must not load IR or advance the PC.
      if (timeout) begin
         ctl.ir_write = 1'b0;
         ctl.pc_write = 1'b0;
      end
   end

   // Reset forces every output low without waiting for a clock edge.
   assign ctl_out = rst_n ? ctl : '0;

   assign bus.pc_write      = ctl_out.pc_write;
   assign bus.pc_write_cond = ctl_out.pc_write_cond;
   assign bus.i_or_d        = ctl_out.i_or_d;
   assign bus.mem_read      = ctl_out.mem_read;
   assign bus.mem_write     = ctl_out.mem_write;
   assign bus.ir_write      = ctl_out.ir_write;
   assign bus.mem_to_reg    = ctl_out.mem_to_reg;
   assign bus.reg_dst       = ctl_out.reg_dst;
   assign bus.reg_write     = ctl_out.reg_write;
   assign bus.alu_src_a     = ctl_out.alu_src_a;
   assign bus.alu_src_b     = ctl_out.alu_src_b;
   assign bus.alu_op        = ctl_out.alu_op;
   assign bus.pc_source     = ctl_out.pc_source;
   assign bus.illegal_op    = ctl_out.illegal_op;
   assign bus.mem_timeout   = ctl_out.mem_timeout;
   assign state_dbg         = state;

   // The wait counter restarts on every state change (and after an abort),
   // so it always measures the stall of the access currently in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FETCH;
         wait_cnt <= 8'd0;
      end else begin
         state <= state_next;
         if (timeout || (state_next != state))
            wait_cnt <= 8'd0;
         else if (is_mem_state(state) && !bus.mem_ready)
            wait_cnt <= wait_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Cycle-by-cycle vector bench for the multicycle MIPS control FSM, plus a
// hand-written asynchronous-reset sequence in the middle of a store.
module tb_mips_multicycle_control;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   // Expected control word, hand-derived per state:
   // {pc_write,pc_write_cond,i_or_d,mem_read,mem_write,ir_write}
   // {mem_to_reg,reg_dst,reg_write,alu_src_a} {alu_src_b} {alu_op} {pc_source}
   // {illegal_op,mem_timeout}
   localparam logic [17:0] C_ZERO     = 18'b000000_0000_00_00_00_00;
   localparam logic [17:0] C_FETCH_W  = 18'b000100_0000_01_00_00_00;
   localparam logic [17:0] C_FETCH_R  = 18'b100101_0000_01_00_00_00;
   localparam logic [17:0] C_FETCH_TO = 18'b000100_0000_01_00_00_01;
   localparam logic [17:0] C_DECODE   = 18'b000000_0000_11_00_00_00;
   localparam logic [17:0] C_DEC_ILL  = 18'b000000_0000_11_00_00_10;
   localparam logic [17:0] C_MEMADDR  = 18'b000000_0001_10_00_00_00;
   localparam logic [17:0] C_MEMRD    = 18'b001100_0000_00_00_00_00;
   localparam logic [17:0] C_MEMRD_TO = 18'b001100_0000_00_00_00_01;
   localparam logic [17:0] C_MEMWB    = 18'b000000_1010_00_00_00_00;
   localparam logic [17:0] C_MEMWR    = 18'b001010_0000_00_00_00_00;
   localparam logic [17:0] C_EXEC     = 18'b000000_0001_00_10_00_00;
   localparam logic [17:0] C_RWB      = 18'b000000_0110_00_00_00_00;
   localparam logic [17:0] C_BRANCH   = 18'b010000_0001_00_01_01_00;
   localparam logic [17:0] C_JUMP     = 18'b100000_0000_00_00_10_00;
   localparam logic [17:0] C_ADDIEX   = 18'b000000_0001_10_00_00_00;
   localparam logic [17:0] C_ADDIWB   = 18'b000000_0010_00_00_00_00;

   typedef struct {
      logic        rst_n;
      logic [5:0]  opcode;
      logic        mem_ready;
      logic        zero;
      logic [3:0]  st;
      logic [17:0] ctl;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] state_dbg;
   logic [17:0] act_ctl;
   int         errors;
   int         checks;
   vec_t       vecs[$];

   mips_multicycle_control_if bus ();

   mips_multicycle_control #(.MEM_WAIT_MAX(8'd4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   assign act_ctl = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                     bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                     bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                     bus.pc_source, bus.illegal_op, bus.mem_timeout};

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic add(input logic r, input logic [5:0] op, input logic rdy,
                      input logic z, input logic [3:0] st, input logic [17:0] ctl);
      vec_t v;
      v.rst_n = r; v.opcode = op; v.mem_ready = rdy; v.zero = z;
      v.st = st; v.ctl = ctl;
      vecs.push_back(v);
   endtask

   task automatic check(input string nm, input int idx,
                        input logic [17:0] act, input logic [17:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %b expected %b", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [5:0] op, input logic rdy, input logic z);
      rst_n         = r;
      bus.opcode    = op;
      bus.mem_ready = rdy;
      bus.zero      = z;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      drive(1'b0, OP_R, 1'b1, 1'b0);

      // reset gating, then R-type: states 0,1,6,7
      add(0, OP_R,   1, 0, 4'd0,  C_ZERO);
      add(1, OP_R,   1, 0, 4'd0,  C_FETCH_R);
      add(1, OP_R,   1, 0, 4'd1,  C_DECODE);
      add(1, OP_R,   1, 0, 4'd6,  C_EXEC);
      add(1, OP_R,   1, 0, 4'd7,  C_RWB);
      // lw with three stalled cycles in MEM_READ: 8 cycles total
      add(1, OP_LW,  1, 0, 4'd0,  C_FETCH_R);
      add(1, OP_LW,  1, 0, 4'd1,  C_DECODE);
      add(1, OP_LW,  1, 0, 4'd2,  C_MEMADDR);
      add(1, OP_LW,  0, 0, 4'd3,  C_MEMRD);
      add(1, OP_LW,  0, 0, 4'd3,  C_MEMRD);
      add(1, OP_LW,  0, 0, 4'd3,  C_MEMRD);
      add(1, OP_LW,  1, 0, 4'd3,  C_MEMRD);
      add(1, OP_LW,  1, 0, 4'd4,  C_MEMWB);
      // sw, beq, j, addi with memory always ready
      add(1, OP_SW,  1, 0, 4'd0,  C_FETCH_R);
      add(1, OP_SW,  1, 0, 4'd1,  C_DECODE);
      add(1, OP_SW,  1, 0, 4'd2,  C_MEMADDR);
      add(1, OP_SW,  1, 0, 4'd5,  C_MEMWR);
      add(1, OP_BEQ, 1, 1, 4'd0,  C_FETCH_R);
      add(1, OP_BEQ, 1, 1, 4'd1,  C_DECODE);
      add(1, OP_BEQ, 1, 1, 4'd8,  C_BRANCH);
      add(1, OP_J,   1, 0, 4'd0,  C_FETCH_R);
      add(1, OP_J,   1, 0, 4'd1,  C_DECODE);
      add(1, OP_J,   1, 0, 4'd9,  C_JUMP);
      add(1, OP_ADDI,1, 0, 4'd0,  C_FETCH_R);
      add(1, OP_ADDI,1, 0, 4'd1,  C_DECODE);
      add(1, OP_ADDI,1, 0, 4'd10, C_ADDIEX);
      add(1, OP_ADDI,1, 0, 4'd11, C_ADDIWB);
      // illegal opcode: one-cycle pulse in DECODE, back to FETCH
      add(1, OP_BAD, 1, 0, 4'd0,  C_FETCH_R);
      add(1, OP_BAD, 1, 0, 4'd1,  C_DEC_ILL);
      // FETCH timeout after 4 wait cycles, twice (counter restarted)
      for (int k = 0; k < 2; k++) begin
         for (int w = 0; w < 4; w++) add(1, OP_R, 0, 0, 4'd0, C_FETCH_W);
         add(1, OP_R, 0, 0, 4'd0, C_FETCH_TO);
      end
      // ready arriving exactly at the limit completes the fetch normally
      for (int w = 0; w < 4; w++) add(1, OP_R, 0, 0, 4'd0, C_FETCH_W);
      add(1, OP_R,   1, 0, 4'd0,  C_FETCH_R);
      add(1, OP_R,   1, 0, 4'd1,  C_DECODE);
      add(1, OP_R,   1, 0, 4'd6,  C_EXEC);
      add(1, OP_R,   1, 0, 4'd7,  C_RWB);
      // MEM_READ timeout aborts to FETCH without writeback
      add(1, OP_LW,  1, 0, 4'd0,  C_FETCH_R);
      add(1, OP_LW,  1, 0, 4'd1,  C_DECODE);
      add(1, OP_LW,  1, 0, 4'd2,  C_MEMADDR);
      for (int w = 0; w < 4; w++) add(1, OP_LW, 0, 0, 4'd3, C_MEMRD);
      add(1, OP_LW,  0, 0, 4'd3,  C_MEMRD_TO);
      add(1, OP_SW,  1, 0, 4'd0,  C_FETCH_R);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].rst_n, vecs[i].opcode, vecs[i].mem_ready, vecs[i].zero);
         #1;
         check("state", i, {14'd0, state_dbg}, {14'd0, vecs[i].st});
         check("ctl", i, act_ctl, vecs[i].ctl);
      end

      // sw stalled in MEM_WRITE, then asynchronous reset mid-cycle
      @(negedge clk);
      drive(1'b1, OP_SW, 1'b1, 1'b0);
      #1 check("seq_decode", 0, {14'd0, state_dbg}, 18'd1);
      @(negedge clk);
      #1 check("seq_memaddr", 1, {14'd0, state_dbg}, 18'd2);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1 check("seq_memwr", 2, act_ctl, C_MEMWR);
      #2 rst_n = 1'b0;
      #1 check("rst_async_ctl", 3, act_ctl, C_ZERO);
      check("rst_async_state", 3, {14'd0, state_dbg}, 18'd0);
      @(negedge clk);
      #1 check("rst_held_ctl", 4, act_ctl, C_ZERO);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("post_rst_state", 5, {14'd0, state_dbg}, 18'd0);
      check("post_rst_ctl", 5, act_ctl, C_FETCH_W);
      @(negedge clk);
      #1 check("post_rst_stay", 6, {14'd0, state_dbg}, 18'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
